// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latq_array.sv
// Latch-based register array: writes are staged on the rising edge and land
// in a row latch during the following CLK-low phase; reads are registered.
module gf180mcu_fd_sc_mcu7t5v0__latq_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BYPASS = 0,
  localparam int unsigned AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  inout  wire              VDD,
  inout  wire              VSS
);

  logic             we_s_q, we_s_d;
  logic [AW-1:0]    wa_s_q, wa_s_d;
  logic [WIDTH-1:0] d_s_q, d_s_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;

  logic [WIDTH-1:0] row_data [DEPTH];
  logic             row_vld  [DEPTH];
  logic [DEPTH-1:0] row_en;

  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Staged controls only change while CLK is high, so gating with ~CLK
  // keeps every row enable free of glitches during the low phase.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic [WIDTH-1:0] row_l;
    logic             vld_l;

    assign row_en[i] = ~CLK & we_s_q & (32'(wa_s_q) == i);

    always_latch begin
      if (!RN) begin
        row_l <= '0;
        vld_l <= 1'b0;
      end else if (row_en[i]) begin
        row_l <= d_s_q;
        vld_l <= 1'b1;
      end
    end

    assign row_data[i] = row_l;
    assign row_vld[i]  = vld_l;
  end

  always_comb begin
    we_s_d = WE;
    wa_s_d = WA;
    d_s_d  = D;
    q_d    = '0;
    qv_d   = 1'b0;
    if (32'(RA) < DEPTH) begin
      if ((BYPASS != 0) && WE && (WA == RA)) begin
        q_d  = D;
        qv_d = 1'b1;
      end else begin
        q_d  = row_data[RA];
        qv_d = row_vld[RA];
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      we_s_q <= 1'b0;
      wa_s_q <= '0;
      d_s_q  <= '0;
      q_q    <= '0;
      qv_q   <= 1'b0;
    end else begin
      we_s_q <= we_s_d;
      wa_s_q <= wa_s_d;
      d_s_q  <= d_s_d;
      q_q    <= q_d;
      qv_q   <= qv_d;
    end
  end

  assign Q  = q_q;
  assign QV = qv_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latq_array.sv
// Bench for the latch array: three configurations driven in parallel and
// compared against an array-based reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__latq_array;

  localparam int N = 3;

  logic       CLK = 1'b0;
  logic       RN  = 1'b1;
  logic       WE  = 1'b0;
  logic [1:0] WA  = '0;
  logic [1:0] RA  = '0;
  logic [7:0] D   = '0;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  logic [7:0] q0, q1, q2;
  logic       qv0, qv1, qv2;

  int n_vec = 0;
  int n_err = 0;

  int unsigned depth_m [N] = '{4, 4, 3};
  bit          byp_m   [N] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  mem     [N][4];
  bit          val     [N][4];
  logic [7:0]  exp_q   [N];
  bit          exp_qv  [N];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__latq_array #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u0 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA),
    .Q(q0), .QV(qv0), .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu7t5v0__latq_array #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u1 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA),
    .Q(q1), .QV(qv1), .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu7t5v0__latq_array #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u2 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA),
    .Q(q2), .QV(qv2), .VDD(vdd), .VSS(vss));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".u0.Q"},  32'(q0),  32'(exp_q[0]));
    check({tag, ".u0.QV"}, 32'(qv0), 32'(exp_qv[0]));
    check({tag, ".u1.Q"},  32'(q1),  32'(exp_q[1]));
    check({tag, ".u1.QV"}, 32'(qv1), 32'(exp_qv[1]));
    check({tag, ".u2.Q"},  32'(q2),  32'(exp_q[2]));
    check({tag, ".u2.QV"}, 32'(qv2), 32'(exp_qv[2]));
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      exp_q[k]  = '0;
      exp_qv[k] = 1'b0;
      for (int r = 0; r < 4; r++) begin
        mem[k][r] = '0;
        val[k][r] = 1'b0;
      end
    end
  endfunction

  // A read at an edge sees every write sampled at earlier edges; the write
  // sampled at this edge is only visible through the bypass path.
  function automatic void model_edge(input bit we, input int unsigned wa,
                                     input logic [7:0] d, input int unsigned ra);
    for (int k = 0; k < N; k++) begin
      if (ra >= depth_m[k]) begin
        exp_q[k]  = '0;
        exp_qv[k] = 1'b0;
      end else if (byp_m[k] && we && wa == ra) begin
        exp_q[k]  = d;
        exp_qv[k] = 1'b1;
      end else begin
        exp_q[k]  = mem[k][ra];
        exp_qv[k] = val[k][ra];
      end
      if (we && wa < depth_m[k]) begin
        mem[k][wa] = d;
        val[k][wa] = 1'b1;
      end
    end
  endfunction

  task automatic cycle(input bit we, input int unsigned wa, input logic [7:0] d,
                       input int unsigned ra, input string tag);
    WE = we;
    WA = 2'(wa);
    D  = d;
    RA = 2'(ra);
    @(posedge CLK);
    model_edge(we, wa, d, ra);
    #1;
    check_all(tag);
  endtask

  // Reset pulse confined to the CLK-low phase, where a staged write is open.
  task automatic reset_pulse(input string tag);
    @(negedge CLK);
    #1 RN = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 RN = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 RN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RN = 1'b1;

    cycle(1, 3, 8'hFF, 0, "d3_wr3");
    cycle(0, 0, 8'h00, 3, "d3_rd3");
    for (int r = 0; r < 3; r++) cycle(0, 0, 8'h00, r, "d3_rd");

    cycle(1, 2, 8'hA5, 0, "wr2");
    cycle(0, 0, 8'h00, 2, "rd2");

    cycle(1, 1, 8'h3C, 1, "same_edge");
    cycle(0, 0, 8'h00, 1, "rd1");

    cycle(1, 3, 8'h01, 0, "b2b_1");
    cycle(1, 3, 8'h02, 1, "b2b_2");
    cycle(1, 3, 8'h03, 2, "b2b_3");
    cycle(0, 0, 8'h00, 3, "b2b_rd");
    cycle(0, 0, 8'h00, 0, "b2b_r0");

    cycle(1, 0, 8'h11, 0, "wr0_a");
    cycle(1, 0, 8'h11, 0, "wr0_b");
    reset_pulse("rst_async");
    cycle(0, 0, 8'h00, 0, "rst_rd0");

    for (int i = 0; i < 400; i++) begin
      bit          we;
      int unsigned wa, ra;
      logic [7:0]  d;
      we = 1'($urandom);
      wa = $urandom_range(3, 0);
      d  = 8'($urandom);
      ra = ($urandom_range(2, 0) == 0) ? wa : $urandom_range(3, 0);
      cycle(we, wa, d, ra, "rand");
      if ($urandom_range(59, 0) == 0) reset_pulse("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__latq_array.md
GF180MCU_FD_SC_MCU7T5V0__LATQ_ARRAY -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__latq_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per word (1..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of latch rows (2..16, need not be a power of 2).
REQ-003 SHALL have parameter BYPASS, default 0, meaning 1 forwards same-edge write data to the read port.
REQ-004 SHALL have derived constant AW = max(1, ceil(log2(DEPTH))), meaning address width.
REQ-005 SHALL have one clock and an asynchronous active-low reset.
REQ-006 SHALL have port CLK  input  1  clock; all sampling is on the rising edge.
REQ-007 SHALL have port RN  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port WE  input  1  write request, sampled at rising CLK.
REQ-009 SHALL have port WA  input  AW  write row address.
REQ-010 SHALL have port D  input  WIDTH  write data.
REQ-011 SHALL have port RA  input  AW  read row address.
REQ-012 SHALL have port Q  output  WIDTH  registered read data.
REQ-013 SHALL have port QV  output  1  registered flag: the row read into Q has been written since reset.
REQ-014 SHALL have ports VDD and VSS  inout  1  supply pins; no functional effect.

Function
REQ-015 SHALL use a write staging register: at rising CLK edge n it captures WE, WA and D into we_s, wa_s and d_s.
REQ-016 SHALL make storage row wa_s transparent to d_s during the CLK-low phase of cycle n when we_s=1; the row closes at rising edge n+1.
REQ-017 SHALL keep the enable of every other row inactive during that phase, with no glitch on any enable.
REQ-018 SHALL register reads: at rising edge n, Q <= row[RA] and QV <= valid[RA], both as they stand immediately before edge n.
REQ-019 SHALL give a write-to-read latency of 1 cycle: a write sampled at edge n is returned by a read sampled at edge n+1 or later.
REQ-020 SHALL, when WE=1 and RA=WA at the same edge with BYPASS=0, return the old row content and old valid flag.
REQ-021 SHALL, in the same case with BYPASS=1, return Q=D and QV=1.
REQ-022 SHALL set valid[wa_s] to 1 when a staged write completes; valid bits are cleared only by reset.
REQ-023 SHALL leave a row's contents and valid bit unchanged when it is not written; all rows hold indefinitely.
REQ-024 SHALL, for WA >= DEPTH, perform no write to any row and set no valid bit.
REQ-025 SHALL, for RA >= DEPTH, return Q=0 and QV=0; no X propagation.
REQ-026 SHALL complete back-to-back writes to the same row on consecutive edges in order; the last write wins.
REQ-027 SHALL let a read and a write on the same edge proceed independently, except as stated in REQ-020 and REQ-021.

Reset
REQ-028 SHALL, while RN=0, asynchronously force Q=0, QV=0, we_s=0, all rows to 0 and all valid bits to 0.
REQ-029 SHALL discard any staged write in flight when RN falls; no row is modified by it.
REQ-030 SHALL ignore WE, WA, D and RA while RN=0.
REQ-031 SHALL release reset without delay: the first rising CLK edge with RN=1 samples inputs normally.

Verification
REQ-032 SHALL cover: reset, then WE=1, WA=2, D=0xA5 at edge 1; RA=2 at edge 2 -> Q=0xA5, QV=1 after edge 2.
REQ-033 SHALL cover: BYPASS=0, WE=1, WA=1, D=0x3C and RA=1 at the same edge, row 1 unwritten -> Q=0x00, QV=0; at the next edge with RA=1 -> Q=0x3C, QV=1.
REQ-034 SHALL cover the same stimulus as REQ-033 with BYPASS=1 -> Q=0x3C, QV=1 at the first edge.
REQ-035 SHALL cover: DEPTH=3, write WA=3, D=0xFF, then read RA=3 and RA=0..2 -> all reads give Q=0, QV=0.
REQ-036 SHALL cover: write row 0 with D=0x11; pulse RN low during the CLK-low phase of that write; read row 0 after release -> Q=0, QV=0, and Q/QV went to 0 immediately when RN fell.
REQ-037 SHALL cover: consecutive writes to row 3 with D=0x01, 0x02, 0x03, then read row 3 -> Q=0x03; rows 0..2 stay unchanged throughout.
